cam_power_seq: RTL
==================

CAM_POWER_SEQ -- requirements
Module: cam_power_seq

Interface
REQ-001 SHALL have parameter LOCK_CYC, default 1024: consecutive pll_lock-high cycles required before the sequence starts.
REQ-002 SHALL have parameter T_CLK, default 2400: cycles from xclk_en rise to cam_pwdn fall (100 us at 24 MHz).
REQ-003 SHALL have parameter T_PWR, default 24000: cycles from cam_pwdn fall to cam_rst_n rise (1 ms).
REQ-004 SHALL have parameter T_RST, default 480000: cycles from cam_rst_n rise to ready rise (20 ms).
REQ-005 SHALL have parameter T_OFF, default 24: cycles xclk_en stays high after an abort.
REQ-006 SHALL have port clk, input, 1: 24 MHz sensor clock from the PLL output; the only clock.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port pll_lock, input, 1: PLL lock indication, synchronised internally with a 2-flop synchroniser.
REQ-009 SHALL have port enable, input, 1: level request to power the sensor pair.
REQ-010 SHALL have port xclk_en, output, 1: gates XCLK to the sensors.
REQ-011 SHALL have port cam_pwdn, output, 1: sensor power-down, active high.
REQ-012 SHALL have port cam_rst_n, output, 1: sensor reset, active low.
REQ-013 SHALL have port ready, output, 1: sensors out of reset; SCCB init may start.
REQ-014 SHALL have port abort_cnt, output, 8: count of aborts caused by lock loss, saturating.

Function
REQ-015 SHALL implement states IDLE, CLK_ON, PWR_UP, RST_REL, READY, OFF.
REQ-016 SHALL register all outputs: IDLE/OFF -> pwdn=1, rst_n=0, ready=0; CLK_ON -> xclk_en=1, pwdn=1; PWR_UP -> pwdn=0, rst_n=0; RST_REL -> rst_n=1; READY -> ready=1.
REQ-017 SHALL count lock_ok cycles with a lock filter; lock_ok asserts after LOCK_CYC consecutive synchronised-high cycles and clears on the first low cycle.
REQ-018 SHALL move IDLE->CLK_ON when enable=1 and lock_ok=1.
REQ-019 SHALL hold each timed state for exactly its parameter's cycle count, with the timer zeroed on state entry: CLK_ON T_CLK, PWR_UP T_PWR, RST_REL T_RST, OFF T_OFF.
REQ-020 SHALL move any state other than IDLE/OFF to OFF on the cycle enable=0 or lock_ok=0; abort takes priority over a simultaneous timer expiry.
REQ-021 SHALL in OFF drive rst_n=0, pwdn=1, ready=0 immediately and keep xclk_en=1 for T_OFF cycles, then go to IDLE with xclk_en=0.
REQ-022 SHALL ignore enable changes during OFF; re-entry occurs only via IDLE.
REQ-023 SHALL increment abort_cnt by one per abort caused by lock_ok=0, saturating at 255; enable-driven aborts do not count.
REQ-024 SHALL size timer width as clog2 of the maximum parameter value, with no wrap within any state.

Reset
REQ-025 SHALL on rst_n=0, asynchronously set state to IDLE, xclk_en=0, cam_pwdn=1, cam_rst_n=0, ready=0, abort_cnt=0, and clear the timer, lock filter and synchroniser.
REQ-026 SHALL restart from IDLE with full LOCK_CYC qualification after a mid-sequence reset.

Structure
REQ-027 SHALL place the state enum and default timing constants in the shared package cam_pkg.
REQ-028 SHALL implement the synchroniser and consecutive-lock counter as sub-module pll_lock_filter.

Verification (LOCK_CYC=4, T_CLK=3, T_PWR=5, T_RST=7, T_OFF=2)
REQ-029 SHALL verify the nominal sequence: lock=1 and enable=1 held -> xclk_en rises; pwdn falls 3 cycles later; rst_n rises 5 cycles after that; ready rises 7 cycles after that.
REQ-030 SHALL verify lock glitch qualification: lock high 3 cycles, low 1, then high -> xclk_en stays 0 until 4 consecutive highs after the glitch.
REQ-031 SHALL verify lock loss in RST_REL: rst_n=0 and pwdn=1 on the next cycle, xclk_en=0 after 2 cycles, abort_cnt=1.
REQ-032 SHALL verify enable drop in READY: ready=0 and rst_n=0 immediately, abort_cnt unchanged, return to IDLE after 2 cycles.
REQ-033 SHALL verify saturation: 300 lock-loss aborts -> abort_cnt=255.
REQ-034 SHALL verify async reset mid-PWR_UP: outputs return to reset values without a clock edge, and the sequence restarts with full qualification.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default timing for the camera power sequencer.
// Defaults assume a 24 MHz sensor clock.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLK_ON,
        PWR_UP,
        RST_REL,
        READY,
        OFF
    } cam_state_e;

    typedef struct packed {
        logic xclk_en;
        logic pwdn;
        logic rst_n;
        logic ready;
    } cam_out_t;

    localparam int DEF_LOCK_CYC = 1024;
    localparam int DEF_T_CLK    = 2400;
    localparam int DEF_T_PWR    = 24000;
    localparam int DEF_T_RST    = 480000;
    localparam int DEF_T_OFF    = 24;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Pin levels driven while in each state.
    function automatic cam_out_t state_outs(input cam_state_e s);
        cam_out_t o;
        o = '{xclk_en: 1'b0, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0};
        case (s)
            CLK_ON:  o = '{xclk_en: 1'b1, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0};
            PWR_UP:  o = '{xclk_en: 1'b1, pwdn: 1'b0, rst_n: 1'b0, ready: 1'b0};
            RST_REL: o = '{xclk_en: 1'b1, pwdn: 1'b0, rst_n: 1'b1, ready: 1'b0};
            READY:   o = '{xclk_en: 1'b1, pwdn: 1'b0, rst_n: 1'b1, ready: 1'b1};
            OFF:     o = '{xclk_en: 1'b1, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0};
            default: o = '{xclk_en: 1'b0, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser plus consecutive-high qualifier for the PLL lock pin.
// lock_ok is high on the LOCK_CYC-th synchronised-high cycle and drops on the first low one.
module pll_lock_filter
    import cam_pkg::*;
#(
    parameter int LOCK_CYC = DEF_LOCK_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_ok
);

    localparam int CW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [CW-1:0] CMAX = CW'(LOCK_CYC - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], pll_lock};
            if (!sync[1])
                cnt <= '0;
            else if (cnt != CMAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign lock_ok = sync[1] && (cnt == CMAX);

endmodule

// File: rtl/cam_power_seq.sv
// Camera sensor power-up sequencer: XCLK, power-down release, reset release, ready.
// Lock loss or enable drop aborts through OFF, which keeps XCLK alive briefly.
module cam_power_seq
    import cam_pkg::*;
#(
    parameter int LOCK_CYC = DEF_LOCK_CYC,
    parameter int T_CLK    = DEF_T_CLK,
    parameter int T_PWR    = DEF_T_PWR,
    parameter int T_RST    = DEF_T_RST,
    parameter int T_OFF    = DEF_T_OFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       enable,
    output logic       xclk_en,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       ready,
    output logic [7:0] abort_cnt
);

    localparam int TMAX = max4(T_CLK, T_PWR, T_RST, T_OFF);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    cam_state_e    state, state_nxt;
    logic [TW-1:0] timer, tlim;
    logic          lock_ok, t_done, abort_lock;
    cam_out_t      out_q;

    pll_lock_filter #(.LOCK_CYC(LOCK_CYC)) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .lock_ok  (lock_ok)
    );

    always_comb begin
        tlim = '0;
        case (state)
            CLK_ON:  tlim = TW'(T_CLK - 1);
            PWR_UP:  tlim = TW'(T_PWR - 1);
            RST_REL: tlim = TW'(T_RST - 1);
            OFF:     tlim = TW'(T_OFF - 1);
            default: tlim = '0;
        endcase
    end

    // Abort is checked before timer expiry so it always wins.
    always_comb begin
        state_nxt  = state;
        abort_lock = 1'b0;
        t_done     = (timer == tlim);
        case (state)
            IDLE: if (enable && lock_ok) state_nxt = CLK_ON;
            OFF:  if (t_done) state_nxt = IDLE;
            default: begin
                if (!enable || !lock_ok) begin
                    state_nxt  = OFF;
                    abort_lock = !lock_ok;
                end else if (t_done) begin
                    case (state)
                        CLK_ON:  state_nxt = PWR_UP;
                        PWR_UP:  state_nxt = RST_REL;
                        RST_REL: state_nxt = READY;
                        default: state_nxt = state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            out_q     <= state_outs(IDLE);
            abort_cnt <= '0;
        end else begin
            state <= state_nxt;
            out_q <= state_outs(state_nxt);
            if (state_nxt != state || state == IDLE || state == READY)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (abort_lock && abort_cnt != 8'hFF)
                abort_cnt <= abort_cnt + 8'd1;
        end
    end

    assign xclk_en   = out_q.xclk_en;
    assign cam_pwdn  = out_q.pwdn;
    assign cam_rst_n = out_q.rst_n;
    assign ready     = out_q.ready;

endmodule
